// File: rtl/fma_pkg.sv
// Shared types for the FMA line writer: controller states and phrase slot indices.
package fma_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      DONE
   } state_t;

   localparam logic [1:0] PHRASE_A = 2'd0;
   localparam logic [1:0] PHRASE_B = 2'd1;
   localparam logic [1:0] PHRASE_C = 2'd2;

endpackage

// File: rtl/fma_line_writer_if.sv
// FMA result stream: lane data/valid from the producer, ready and phrase slot back.
interface fma_line_writer_if #(
   parameter int FMA_COUNT  = 2,
   parameter int WORD_WIDTH = 16
);
   localparam int PW = FMA_COUNT * WORD_WIDTH;

   logic [PW-1:0]        fma_data_in;
   logic [FMA_COUNT-1:0] fma_valid_in;
   logic                 ready_out;
   logic [1:0]           phrase_num_out;

   modport master (
      output fma_data_in,
      output fma_valid_in,
      input  ready_out,
      input  phrase_num_out
   );

   modport slave (
      input  fma_data_in,
      input  fma_valid_in,
      output ready_out,
      output phrase_num_out
   );

endinterface

// File: rtl/fma_line_assembler.sv
// Three-slot line register: phrase a/b/c are loaded into their slot, clear wipes the line.
module fma_line_assembler
   import fma_pkg::*;
#(
   parameter int PW = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            load,
   input  logic [1:0]      slot,
   input  logic [PW-1:0]   data,
   input  logic            clear,
   output logic [3*PW-1:0] line
);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         line <= '0;
      end else if (clear) begin
         line <= '0;
      end else if (load) begin
         case (slot)
            PHRASE_A: line[PW-1:0]      <= data;
            PHRASE_B: line[2*PW-1:PW]   <= data;
            PHRASE_C: line[3*PW-1:2*PW] <= data;
            default:  line              <= line;
         endcase
      end
   end

endmodule

// File: rtl/fma_line_writer.sv
// Collects three FMA phrases (a, b, c) into one BRAM line and writes a job of lines
// to consecutive, wrapping addresses.
module fma_line_writer
   import fma_pkg::*;
#(
   parameter int FMA_COUNT  = 2,
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic [ADDR_WIDTH-1:0] base_addr_in,
   input  logic [ADDR_WIDTH-1:0] line_count_in,
   fma_line_writer_if.slave      fma,
   output logic [ADDR_WIDTH-1:0] bram_addr_out,
   output logic [3*FMA_COUNT*WORD_WIDTH-1:0] bram_data_out,
   output logic                  bram_we_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  error_out
);

   localparam int PW         = FMA_COUNT * WORD_WIDTH;
   localparam int LINE_WIDTH = 3 * PW;
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] count_q;
   logic [ADDR_WIDTH-1:0] lines_written;
   logic [ADDR_WIDTH-1:0] lines_inc;
   logic [1:0]            phrase_num;
   logic                  error_q;
   logic                  all_valid;
   logic                  any_valid;
   logic                  accept;
   logic                  partial;
   logic [LINE_WIDTH-1:0] line;

   always_comb begin
      all_valid = &fma.fma_valid_in;
      any_valid = |fma.fma_valid_in;
      accept    = (state == COLLECT) && all_valid;
      partial   = (state == COLLECT) && any_valid && !all_valid;
      lines_inc = lines_written + ONE;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_in) begin
               state_next = (line_count_in == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (accept && (phrase_num == PHRASE_C)) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            // lines_inc is the post-write count, so this compares against lines done
            state_next = (lines_inc == count_q) ? DONE : COLLECT;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         base_q        <= '0;
         count_q       <= '0;
         lines_written <= '0;
         phrase_num    <= PHRASE_A;
         error_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_in) begin
                  base_q        <= base_addr_in;
                  count_q       <= line_count_in;
                  lines_written <= '0;
                  phrase_num    <= PHRASE_A;
                  error_q       <= 1'b0;
               end
            end
            COLLECT: begin
               if (partial) begin
                  error_q <= 1'b1;
               end
               if (accept) begin
                  phrase_num <= (phrase_num == PHRASE_C) ? PHRASE_A : phrase_num + 2'd1;
               end
            end
            WRITE: begin
               lines_written <= lines_inc;
            end
            default: begin
            end
         endcase
      end
   end

   fma_line_assembler #(.PW(PW)) u_assembler (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .load   (accept),
      .slot   (phrase_num),
      .data   (fma.fma_data_in),
      .clear  (state == WRITE),
      .line   (line)
   );

   always_comb begin
      fma.ready_out      = (state == COLLECT);
      fma.phrase_num_out = phrase_num;
      bram_addr_out      = base_q + lines_written;
      bram_data_out      = line;
      bram_we_out        = (state == WRITE);
      busy_out           = (state != IDLE);
      done_out           = (state == DONE);
      error_out          = error_q;
   end

endmodule
